// File: rtl/mw_stage_controller.sv
// Memory/writeback stage controller for the 3-stage RV32I core: data-memory handshake,
// pipeline stall/flush generation, execute forwarding selects and a stall-cycle counter.
module mw_stage_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_rd_MW,
  input  logic             mem_wr_MW,
  input  logic             reg_wr_MW,
  input  logic [4:0]       waddr_MW,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic             br_taken_E,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             Stall_IF,
  output logic             Stall_MW,
  output logic             Flush_MW,
  output logic             ForwardA,
  output logic             ForwardB,
  output logic             load_done,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             load_q, load_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic req, we, stall, ld_done, berr, timeout, mem_op;

  assign mem_op  = mem_rd_MW | mem_wr_MW;
  assign timeout = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // The IDLE cycle that first sees a memory op already acts as the first request cycle.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    load_d  = load_q;
    req     = 1'b0;
    we      = 1'b0;
    stall   = 1'b0;
    ld_done = 1'b0;
    berr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          req    = 1'b1;
          we     = mem_wr_MW;
          stall  = 1'b1;
          load_d = mem_rd_MW;
          tmo_d  = TW'(1);
          if (dmem_gnt) state_d = (mem_rd_MW && !dmem_rvalid) ? WAIT_RSP : DONE;
          else          state_d = REQ;
        end
      end
      REQ: begin
        req   = 1'b1;
        we    = mem_wr_MW;
        stall = 1'b1;
        if (timeout) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (dmem_gnt) state_d = (load_q && !dmem_rvalid) ? WAIT_RSP : DONE;
        end
      end
      WAIT_RSP: begin
        stall = 1'b1;
        if (timeout) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (dmem_rvalid) state_d = DONE;
        end
      end
      DONE: begin
        ld_done = load_q;
        state_d = IDLE;
      end
      ERR: begin
        berr    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must silence every output at once, even though IDLE decodes mem ops combinationally.
  assign dmem_req  = rst & req;
  assign dmem_we   = rst & we;
  assign Stall_MW  = rst & stall;
  assign Stall_IF  = Stall_MW;
  assign load_done = rst & ld_done;
  assign bus_err   = rst & berr;
  assign Flush_MW  = rst & ~stall & (br_taken_E | flush_pend_q);
  assign ForwardA  = rst & reg_wr_MW & (waddr_MW != 5'd0) & (waddr_MW == rs1_E) & ~mem_rd_MW;
  assign ForwardB  = rst & reg_wr_MW & (waddr_MW != 5'd0) & (waddr_MW == rs2_E) & ~mem_rd_MW;
  assign stall_cycles = stall_cnt_q;

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (!Stall_MW)       flush_pend_d = 1'b0;
    else if (br_taken_E) flush_pend_d = 1'b1;
    stall_cnt_d = stall_cnt_q;
    if (Stall_MW && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      load_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      load_q       <= load_d;
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule
